// File: rtl/lsu_mem_access.sv
// Load/store access sequencer between the execute stage and the data RAM port.
// One request in flight; misaligned requests are answered without memory traffic.

package ram_mask_pkg;
  typedef enum logic [1:0] {
    RAM_MASK_B = 2'd0,
    RAM_MASK_H = 2'd1,
    RAM_MASK_W = 2'd2
  } ram_mask_e;
endpackage

module lsu_mem_access
  import ram_mask_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  ram_mask_e         req_mask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_misaligned,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitR, StResp} state_e;

  state_e             state_q, state_d;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [3:0]         be_q;
  logic [31:0]        wdata_q;
  logic [1:0]         off_q;
  logic [31:0]        rdata_q;
  logic               misaligned_q;

  logic [1:0]         req_off;
  logic [3:0]         req_be;
  logic [31:0]        req_wdata_rep;
  logic               req_misaligned;
  logic               accept;
  logic               capture;

  // Unknown width encodings fall into the word case.
  always_comb begin
    req_off = req_addr[1:0];
    case (req_mask)
      RAM_MASK_B: begin
        req_be         = 4'b0001 << req_off;
        req_wdata_rep  = {4{req_wdata[7:0]}};
        req_misaligned = 1'b0;
      end
      RAM_MASK_H: begin
        req_be         = 4'b0011 << req_off;
        req_wdata_rep  = {2{req_wdata[15:0]}};
        req_misaligned = req_off[0];
      end
      default: begin
        req_be         = 4'b1111;
        req_wdata_rep  = req_wdata;
        req_misaligned = (req_off != 2'b00);
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_d = req_misaligned ? StResp : StIssue;
        end
      end
      StIssue: begin
        if (mem_gnt) state_d = we_q ? StResp : StWaitR;
      end
      StWaitR: begin
        if (mem_rvalid) begin
          capture = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      we_q         <= 1'b0;
      addr_q       <= '0;
      be_q         <= 4'b0000;
      wdata_q      <= '0;
      off_q        <= 2'b00;
      rdata_q      <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q         <= req_we;
        addr_q       <= {req_addr[ADDR_W-1:2], 2'b00};
        be_q         <= req_be;
        wdata_q      <= req_wdata_rep;
        off_q        <= req_off;
        rdata_q      <= '0;
        misaligned_q <= req_misaligned;
      end
      // Lane select only; width masking and extension happen downstream.
      if (capture) rdata_q <= mem_rdata >> {off_q, 3'b000};
    end
  end

  assign req_ready      = (state_q == StIdle);
  assign rsp_valid      = (state_q == StResp);
  assign rsp_rdata      = rdata_q;
  assign rsp_misaligned = misaligned_q;
  assign mem_req        = (state_q == StIssue);
  assign mem_we         = we_q;
  assign mem_addr       = addr_q;
  assign mem_be         = be_q;
  assign mem_wdata      = wdata_q;

endmodule
